// File: rtl/pipe_stage_if.sv
// pipe_stage_if -- valid/ready handshake bundle for one pipe_stage.
//
// Carries both the upstream (in_*) and downstream (out_*) handshakes of
// the stage so the stage and its environment connect through one port.
//   in_valid  : upstream beat present
//   in_ready  : stage accepts a beat this cycle
//   in_data   : upstream payload (WIDTH bits)
//   out_valid : downstream beat present
//   out_ready : downstream accepts this cycle
//   out_data  : downstream payload (WIDTH bits)
// Modports:
//   slave  : the pipe stage itself
//   master : the environment driving the upstream side and sinking the
//            downstream side
interface pipe_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage.sv
// pipe_stage -- one-cycle-latency valid/ready register slice.
//
// Buffering mode is selected by the macro PIPE_STAGE_SKID_EN:
//   undefined : single register, in_ready combinational from out_ready
//   defined   : main + skid register with EMPTY/BUSY/FULL state machine,
//               in_ready is a register output (no path from out_ready)
//
// Ports:
//   clk       : sole clock, rising edge
//   rst_n     : asynchronous active-low reset
//   flush     : synchronous discard of all held beats (and of any beat
//               offered on the input the same cycle)
//   bus       : pipe_stage_if.slave, upstream and downstream handshakes
//   occupancy : number of held beats (0..2)
//   stall_cnt : saturating count of cycles with out_valid=1, out_ready=0
//
// Parameters:
//   WIDTH  : payload width (1..128)
//   BUBBLE : value shown on out_data whenever out_valid=0
module pipe_stage #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  pipe_stage_if.slave  bus,
  output logic [1:0]   occupancy,
  output logic [15:0]  stall_cnt
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [WIDTH-1:0] main_p0;
  logic             vld_p0;
  logic             in_xfer;
  logic             out_xfer;

  // flush wins over any transfer in the same cycle
  assign in_xfer  = bus.in_valid & bus.in_ready & ~flush;
  assign out_xfer = vld_p0 & bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rdy_q;
  logic [WIDTH-1:0] skid_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != FULL);
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_xfer) state_nxt = BUSY;
        BUSY: begin
          if (in_xfer && !out_xfer)      state_nxt = FULL;
          else if (!in_xfer && out_xfer) state_nxt = EMPTY;
        end
        FULL:    if (out_xfer) state_nxt = BUSY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage 0/1 data: main holds the head beat, skid catches the beat that
  // arrives while the head is stalled; skid drains into main on output.
  always_ff @(posedge clk) begin
    case (state)
      EMPTY: if (in_xfer) main_p0 <= bus.in_data;
      BUSY: begin
        if (in_xfer && out_xfer) main_p0 <= bus.in_data;
        else if (in_xfer)        skid_p1 <= bus.in_data;
      end
      FULL:    if (out_xfer) main_p0 <= skid_p1;
      default: ;
    endcase
  end

  assign vld_p0       = (state != EMPTY);
  assign occupancy    = state;
  // Held low while reset is asserted; otherwise a pure register output.
  assign bus.in_ready = rst_n & rdy_q;

`else

  logic vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        vld_q <= 1'b0;
    else if (flush)    vld_q <= 1'b0;
    else if (in_xfer)  vld_q <= 1'b1;
    else if (out_xfer) vld_q <= 1'b0;
  end

  // Stage 0 data: loaded only on an input transfer
  always_ff @(posedge clk) begin
    if (in_xfer) main_p0 <= bus.in_data;
  end

  assign vld_p0       = vld_q;
  assign occupancy    = {1'b0, vld_q};
  assign bus.in_ready = rst_n & (~vld_q | bus.out_ready);

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= 16'd0;
    else if (vld_p0 && !bus.out_ready && !flush)
      stall_cnt <= sat_inc16(stall_cnt);
  end

  assign bus.out_valid = vld_p0;
  assign bus.out_data  = vld_p0 ? main_p0 : BUBBLE;

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage -- self-checking bench for pipe_stage (either buffering
// mode). A scoreboard queue holds accepted beats; every cycle the held
// state, handshake and stall counter are compared against it, and each
// output transfer pops and compares the head beat.
module tb_pipe_stage;
  localparam int          W   = 32;
  localparam logic [31:0] BUB = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_SKID_EN
  localparam int MAXOCC = 2;
`else
  localparam int MAXOCC = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  pipe_stage_if #(.WIDTH(W)) bus ();

  pipe_stage #(.WIDTH(W), .BUBBLE(BUB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] sb_q[$];
  logic [15:0] m_stall = 16'd0;
  logic        mon_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Drive one cycle of inputs just after a rising edge, return 1 time unit
  // after the next rising edge.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / model, sampled mid-cycle where everything is settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_stall = 16'd0;
    end else if (mon_en) begin
      logic exp_rdy;
`ifdef PIPE_STAGE_SKID_EN
      exp_rdy = (sb_q.size() < 2);
`else
      exp_rdy = (sb_q.size() == 0) || bus.out_ready;
`endif
      chk("occ", {30'd0, occupancy}, sb_q.size());
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, sb_q.size() != 0});
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      chk("stall", {16'd0, stall_cnt}, {16'd0, m_stall});
      if (sb_q.size() == 0) chk("bubble", bus.out_data, BUB);

      if (flush) begin
        sb_q.delete();
      end else begin
        if (sb_q.size() != 0 && !bus.out_ready && m_stall != 16'hFFFF)
          m_stall = m_stall + 16'd1;
        if (bus.out_valid && bus.out_ready) begin
          if (sb_q.size() == 0) chk("unexpected_beat", bus.out_data, BUB);
          else chk("out_data", bus.out_data, sb_q.pop_front());
        end
        if (bus.in_valid && exp_rdy) begin
          if (sb_q.size() >= MAXOCC) chk("overfill", sb_q.size(), MAXOCC - 1);
          sb_q.push_back(bus.in_data);
        end
      end
    end
  end

  initial begin
    logic [15:0] s0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, BUB);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Throughput: one beat per cycle, one cycle latency.
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, i, 1'b1, 1'b0);
      chk("thru_data", bus.out_data, i);
      chk("thru_occ", {30'd0, occupancy}, 32'd1);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("thru_drain", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure.
    s0 = stall_cnt;
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    chk("bp_head", bus.out_data, 32'hA);
`ifdef PIPE_STAGE_SKID_EN
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp_occ2", {30'd0, occupancy}, 32'd2);
    chk("bp_rdy0", {31'd0, bus.in_ready}, 32'd0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    chk("bp_hold", bus.out_data, 32'hA);
    chk("bp_stall", {16'd0, stall_cnt}, {16'd0, s0 + 16'd3});
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    chk("bp_second", bus.out_data, 32'hB);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    chk("bp_third", bus.out_data, 32'hC);
`else
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp_rdy0", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_hold", bus.out_data, 32'hA);
    chk("bp_stall", {16'd0, stall_cnt}, {16'd0, s0 + 16'd1});
    cyc(1'b1, 32'hB, 1'b1, 1'b0);
    chk("bp_second", bus.out_data, 32'hB);
`endif
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("bp_drain", {30'd0, occupancy}, 32'd0);

    // Flush with a beat offered the same cycle.
    cyc(1'b1, 32'h7, 1'b0, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b0);
    chk("fl_pre_occ", {30'd0, occupancy}, MAXOCC);
    s0 = stall_cnt;
    cyc(1'b1, 32'h5, 1'b0, 1'b1);
    chk("fl_occ", {30'd0, occupancy}, 32'd0);
    chk("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_data", bus.out_data, BUB);
    chk("fl_stall_kept", {16'd0, stall_cnt}, {16'd0, s0});
    repeat (3) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("fl_no_5", {31'd0, bus.out_valid}, 32'd0);

    // Saturation of the stall counter.
    cyc(1'b1, 32'h9, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
    repeat (10) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("sat_data", bus.out_data, 32'h9);

    // Asynchronous reset mid-stream with one beat held.
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ar_data", bus.out_data, BUB);
    chk("ar_stall", {16'd0, stall_cnt}, 32'd0);
    chk("ar_occ", {30'd0, occupancy}, 32'd0);
    chk("ar_rdy", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ar_rel_rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("ar_rel_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h100 + i, 1'b1, 1'b0);
    chk("ar_recover", bus.out_data, 32'h102);
    repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("end_empty", {30'd0, occupancy}, 32'd0);
    chk("end_sb", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (legal 1..128).
REQ-002 SHALL have parameter BUBBLE, default 0, WIDTH-bit value driven on out_data whenever out_valid=0.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held beats.
REQ-006 SHALL have port in_valid  input  1  upstream beat present.
REQ-007 SHALL have port in_ready  output  1  stage accepts a beat this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  downstream beat present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-012 SHALL have port occupancy  output  2  number of held beats (0..2).
REQ-013 SHALL have port stall_cnt  output  16  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Input transfer SHALL occur iff in_valid=1 and in_ready=1 at a rising edge; output transfer iff out_valid=1 and out_ready=1.
REQ-015 Beats SHALL leave in acceptance order, none duplicated or dropped except by flush or reset.
REQ-016 Latency SHALL be 1 cycle: a beat accepted into an empty stage is presented on out_valid/out_data in the next cycle.
REQ-017 in_data SHALL be sampled only on an input transfer; held payload SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 out_data SHALL equal BUBBLE whenever out_valid=0.
REQ-019 Simultaneous input and output transfer SHALL leave occupancy unchanged, providing full throughput (one beat per cycle).
REQ-020 flush=1 SHALL, at the rising edge, clear all held beats (occupancy 0, out_valid 0); any beat presented on in_data that cycle SHALL be discarded even if in_ready=1.
REQ-021 flush SHALL take priority over every transfer in the same cycle; stall_cnt SHALL NOT be cleared by flush.
REQ-022 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0 and flush=0, saturating at 16'hFFFF.
REQ-023 out_valid SHALL be 1 iff occupancy is nonzero.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, force out_valid=0, out_data=BUBBLE, occupancy=0, stall_cnt=0, all internal valid state cleared.
REQ-025 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after rst_n deasserts.
REQ-026 A reset asserted mid-transfer SHALL discard all held beats; no partial beat SHALL appear after reset.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN SHALL select the buffering mode.
REQ-028 Without PIPE_STAGE_SKID_EN: single register, occupancy max 1, in_ready = (occupancy==0) or out_ready (combinational from out_ready).
REQ-029 With PIPE_STAGE_SKID_EN: main register plus one skid register, state machine EMPTY(0), BUSY(1), FULL(2); in_ready SHALL be a register output equal to (state != FULL), with no combinational path from out_ready.
REQ-030 Skid transitions: EMPTY->BUSY on input transfer; BUSY->FULL on input without output; BUSY->EMPTY on output without input; FULL->BUSY on output (no input possible); all others hold; any state->EMPTY on flush.
REQ-031 In FULL, output transfer SHALL move the skid beat into the main register the same edge, preserving order.

Verification
REQ-032 Reset: rst_n=0 mid-stream with occupancy=1 -> out_valid=0, out_data=BUBBLE, stall_cnt=0 without a clock edge; in_ready=1 first cycle after release.
REQ-033 Throughput: in_valid=1, out_ready=1 continuous, in_data 1,2,3,4 -> out_data 1,2,3,4 on consecutive cycles starting one cycle later, occupancy stays 1.
REQ-034 Backpressure (SKID_EN): in_data A,B,C with out_ready=0 -> A, B accepted, occupancy 2, in_ready=0, C held upstream; out_ready=1 -> A, B, C emerge in order; stall_cnt counts the stalled cycles.
REQ-035 Flush: occupancy 2, flush=1 with in_valid=1, in_data=5 -> next cycle occupancy 0, out_valid=0, out_data=BUBBLE, 5 never emerges, stall_cnt retained.
REQ-036 Saturation: out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and held there.
